// File: rtl/ibex_dii_pkg.sv
// Shared types and constants for the RVFI-DII instruction feeder.
// Imported by the feeder top and its instruction FIFO.
package ibex_dii_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] insn;
    } dii_insn_t;

    // addi x0,x0,0
    localparam logic [31:0] DII_NOP = 32'h0000_0013;

    localparam int unsigned DiiDefaultDepth = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned dii_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(DiiDefaultDepth + 1)-1:0] dii_cnt_t;

endpackage

// File: rtl/ibex_dii_insn_fifo.sv
// Synchronous FIFO of DII instructions with single-cycle flush.
// Pointers wrap by explicit compare so Depth need not be a power of two.
module ibex_dii_insn_fifo
    import ibex_dii_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned CntW  = dii_cnt_w(Depth),
    localparam int unsigned PtrW  = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  dii_insn_t       wdata_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output dii_insn_t       rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    dii_insn_t       mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_en, pop_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            if (pop_en)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            if (push_en && !pop_en)      count_d = count_q + 1'b1;
            else if (pop_en && !push_en) count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy guards every read of a stale entry.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED(39,32) encoder: data passes through, check bits in [38:32].
// The inversion keeps an all-zero word from producing an all-zero codeword.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    always_comb begin
        data_o     = 39'(data_i);
        data_o[32] = ^(data_o & 39'h00_2606_BD25);
        data_o[33] = ^(data_o & 39'h00_DEBA_8050);
        data_o[34] = ^(data_o & 39'h00_413D_89AA);
        data_o[35] = ^(data_o & 39'h00_3123_4ED1);
        data_o[36] = ^(data_o & 39'h00_C2C1_323B);
        data_o[37] = ^(data_o & 39'h00_2DCC_624C);
        data_o[38] = ^(data_o & 39'h00_9850_5586);
        data_o     = data_o ^ 39'h2A_0000_0000;
    end

endmodule

// File: rtl/ibex_dii_instr_feeder.sv
// Answers Ibex instruction fetches with DII-pushed words in push order, ignoring the address.
// One response register gives fixed 1-cycle latency with at most one response in flight.
module ibex_dii_instr_feeder
    import ibex_dii_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter logic [31:0] NopInsn = DII_NOP
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            dii_valid_i,
    output logic                            dii_ready_o,
    input  logic [31:0]                     dii_insn_i,
    input  logic                            dii_err_i,
    input  logic                            drain_i,
    input  logic                            flush_i,
    input  logic                            instr_req_i,
    input  logic [31:0]                     instr_addr_i,
    output logic                            instr_gnt_o,
    output logic                            instr_rvalid_o,
    output logic [31:0]                     instr_rdata_o,
    output logic [6:0]                      instr_rdata_intg_o,
    output logic                            instr_err_o,
    output logic [31:0]                     last_addr_o,
    output logic [dii_cnt_w(Depth)-1:0]     count_o
);

    dii_insn_t   push_data, head, nop_rsp, rsp_q, rsp_d, rsp_out;
    logic        full, empty, push, pop, gnt, rvalid_q;
    logic [31:0] last_addr_q;
    logic [38:0] enc;
    logic        unused_enc;

    assign nop_rsp   = '{err: 1'b0, insn: NopInsn};
    assign push_data = '{err: dii_err_i, insn: dii_insn_i};

    assign dii_ready_o = !full;
    assign push        = dii_valid_i && !full && !flush_i;
    assign gnt         = instr_req_i && !flush_i && (!empty || drain_i);
    assign pop         = gnt && !empty;
    assign instr_gnt_o = gnt;

    ibex_dii_insn_fifo #(.Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .flush_i (flush_i),
        .rdata_o (head),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // A flush in a response cycle still delivers the beat, but as a NOP from the new trace's view.
    always_comb begin
        rsp_d = rsp_q;
        if (gnt)                      rsp_d = empty ? nop_rsp : head;
        else if (flush_i && rvalid_q) rsp_d = nop_rsp;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q    <= 1'b0;
            rsp_q       <= '0;
            last_addr_q <= '0;
        end else begin
            rvalid_q <= gnt;
            rsp_q    <= rsp_d;
            if (gnt) last_addr_q <= instr_addr_i;
        end
    end

    assign rsp_out = (flush_i && rvalid_q) ? nop_rsp : rsp_q;

    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rsp_out.insn;
    assign instr_err_o    = rsp_out.err;
    assign last_addr_o    = last_addr_q;

    prim_secded_inv_39_32_enc u_intg_enc (
        .data_i (rsp_out.insn),
        .data_o (enc)
    );

    assign instr_rdata_intg_o = enc[38:32];
    assign unused_enc         = ^enc[31:0];

endmodule

// File: tb/tb_ibex_dii_instr_feeder.sv
// Directed bench for ibex_dii_instr_feeder: a reference FIFO model and response scoreboard
// are evaluated on every falling edge while one initial block drives the directed steps.
module tb_ibex_dii_instr_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             dii_valid_i = 1'b0;
    logic             dii_ready_o;
    logic [31:0]      dii_insn_i = '0;
    logic             dii_err_i = 1'b0;
    logic             drain_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             instr_req_i = 1'b0;
    logic [31:0]      instr_addr_i = 32'h0000_1000;
    logic             instr_gnt_o;
    logic             instr_rvalid_o;
    logic [31:0]      instr_rdata_o;
    logic [6:0]       instr_rdata_intg_o;
    logic             instr_err_o;
    logic [31:0]      last_addr_o;
    logic [CNT_W-1:0] count_o;

    ibex_dii_instr_feeder #(.Depth(DEPTH), .NopInsn(NOP)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .dii_valid_i        (dii_valid_i),
        .dii_ready_o        (dii_ready_o),
        .dii_insn_i         (dii_insn_i),
        .dii_err_i          (dii_err_i),
        .drain_i            (drain_i),
        .flush_i            (flush_i),
        .instr_req_i        (instr_req_i),
        .instr_addr_i       (instr_addr_i),
        .instr_gnt_o        (instr_gnt_o),
        .instr_rvalid_o     (instr_rvalid_o),
        .instr_rdata_o      (instr_rdata_o),
        .instr_rdata_intg_o (instr_rdata_intg_o),
        .instr_err_o        (instr_err_o),
        .last_addr_o        (last_addr_o),
        .count_o            (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inverted Hsiao(39,32) check bits, written from the code's parity masks.
    function automatic logic [6:0] exp_intg(input logic [31:0] d);
        logic [31:0] masks [7];
        logic [6:0]  c;
        masks = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
                  32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
        for (int i = 0; i < 7; i++) c[i] = ^(d & masks[i]);
        return c ^ 7'h2A;
    endfunction

    // Reference model state: buffered words and expected responses, {err, insn}.
    logic [32:0] m_fifo [$];
    logic [32:0] sb [$];
    logic        m_rvalid = 1'b0;
    logic [31:0] m_last   = '0;

    always @(negedge clk_i) begin
        logic [32:0] exp_rsp;
        logic        exp_gnt;
        int          size_before;
        if (!rst_ni) begin
            m_fifo.delete();
            sb.delete();
            m_rvalid = 1'b0;
            m_last   = '0;
        end else begin
            size_before = m_fifo.size();
            check("count", 64'(count_o), 64'(size_before));
            check("ready", 64'(dii_ready_o), 64'(size_before < DEPTH));
            check("rvalid", 64'(instr_rvalid_o), 64'(m_rvalid));
            check("last_addr", 64'(last_addr_o), 64'(m_last));
            if (instr_rvalid_o) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_rsp = sb.pop_front();
                    if (flush_i) exp_rsp = {1'b0, NOP};
                    check("rdata", 64'(instr_rdata_o), 64'(exp_rsp[31:0]));
                    check("err", 64'(instr_err_o), 64'(exp_rsp[32]));
                    check("intg", 64'(instr_rdata_intg_o), 64'(exp_intg(exp_rsp[31:0])));
                end
            end
            exp_gnt = instr_req_i && !flush_i && (size_before != 0 || drain_i);
            check("gnt", 64'(instr_gnt_o), 64'(exp_gnt));

            m_rvalid = exp_gnt;
            if (exp_gnt) begin
                m_last = instr_addr_i;
                if (size_before != 0) sb.push_back(m_fifo.pop_front());
                else                  sb.push_back({1'b0, NOP});
            end
            if (flush_i) m_fifo.delete();
            else if (dii_valid_i && size_before < DEPTH) m_fifo.push_back({dii_err_i, dii_insn_i});
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        instr_addr_i = instr_addr_i + 32'd4;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            dii_valid_i = 1'b1;
            dii_insn_i  = base + 32'(i);
            step();
        end
        dii_valid_i = 1'b0;
    endtask

    initial begin
        // Reset values, observed while reset is held.
        #2;
        check("rst_gnt", 64'(instr_gnt_o), 64'd0);
        check("rst_rvalid", 64'(instr_rvalid_o), 64'd0);
        check("rst_err", 64'(instr_err_o), 64'd0);
        check("rst_rdata", 64'(instr_rdata_o), 64'd0);
        check("rst_intg", 64'(instr_rdata_intg_o), 64'h2A);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(dii_ready_o), 64'd1);
        check("rst_last_addr", 64'(last_addr_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Three words, continuous fetch: three back-to-back grants then gnt low.
        dii_valid_i = 1'b1; dii_insn_i = 32'h00A0_0093; step();
        dii_insn_i = 32'h00B0_0113; step();
        dii_insn_i = 32'h00C0_0193; step();
        dii_valid_i = 1'b0;
        instr_req_i = 1'b1;
        repeat (5) step();
        instr_req_i = 1'b0;
        step();

        // Fill to full, then a grant with a push that is refused, then accepted.
        push_words(32'h1111_0000, 4);
        instr_req_i = 1'b1;
        dii_valid_i = 1'b1;
        dii_insn_i  = 32'h2222_0000;
        step();
        step();
        dii_valid_i = 1'b0;
        repeat (5) step();
        instr_req_i = 1'b0;
        step();

        // Injected bus error travels with its word.
        dii_valid_i = 1'b1; dii_err_i = 1'b1; dii_insn_i = 32'hDEAD_BEEF;
        step();
        dii_valid_i = 1'b0; dii_err_i = 1'b0;
        instr_req_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        repeat (2) step();

        // Empty without drain: no grants; with drain: NOP response.
        instr_req_i = 1'b1;
        repeat (10) step();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        instr_req_i = 1'b0;
        repeat (2) step();

        // Flush during a pending response, then a fresh word is served.
        push_words(32'h3333_0000, 2);
        instr_req_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        dii_valid_i = 1'b1; dii_insn_i = 32'h0440_0213;
        step();
        dii_valid_i = 1'b0;
        instr_req_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        repeat (2) step();

        // Asynchronous reset with three buffered words and a response in flight.
        push_words(32'h5555_0000, 4);
        instr_req_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        #1;
        check("pre_rst_count", 64'(count_o), 64'd3);
        check("pre_rst_rvalid", 64'(instr_rvalid_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_rvalid", 64'(instr_rvalid_o), 64'd0);
        check("arst_gnt", 64'(instr_gnt_o), 64'd0);
        check("arst_err", 64'(instr_err_o), 64'd0);
        check("arst_rdata", 64'(instr_rdata_o), 64'd0);
        check("arst_intg", 64'(instr_rdata_intg_o), 64'h2A);
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_ready", 64'(dii_ready_o), 64'd1);
        check("arst_last_addr", 64'(last_addr_o), 64'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        repeat (3) step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
